// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared definitions for mem_ctrl: FSM state encoding,
//                transfer-length codes and byte-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Byte counter width; a transfer never exceeds 4 bytes plus one
    // trailing read-capture cycle, so counts 0..4 must fit.
    localparam int CNT_W = 3;

    // Transfer length codes on mem_len_i; any 1x code means a full word.
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;

    // Instruction fetches are always a full word.
    localparam logic [CNT_W-1:0] IF_BYTES = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

    // Number of bytes moved for a given length code.
    function automatic logic [CNT_W-1:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buf
//  Description : One-entry instruction fetch buffer (valid, tag, data).
//                Hits on an exact fetch-address match; filled when a RAM
//                fetch completes; dropped when a written byte lands in any
//                word the cached fetch covers. Only instantiated by mem_ctrl
//                when MEM_CTRL_FETCH_BUF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [31:0]       fill_data,
    input  logic              wr_en,
    input  logic [ADDR_W-3:0] wr_word
);

    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [31:0]       data;
    logic [ADDR_W-3:0] tag_word;
    logic [ADDR_W-3:0] tag_word_end;
    logic              wr_clash;

    // An unaligned fetch spills into the following word, so both words
    // it touches are guarded against stores.
    assign tag_word     = tag[ADDR_W-1:2];
    assign tag_word_end = tag_word + {{(ADDR_W-3){1'b0}}, |tag[1:0]};
    assign wr_clash     = wr_en && ((wr_word == tag_word) || (wr_word == tag_word_end));

    assign hit      = valid && (lookup_addr == tag);
    assign hit_data = data;

    // Entry update: a completed fetch refills, an overlapping store invalidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_addr;
            data  <= fill_data;
        end else if (wr_clash) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Arbitrates an instruction-fetch read port and a load/store
//                port onto one byte-wide synchronous RAM. Multi-byte accesses
//                are serialised byte by byte, little-endian, zero-extended.
//                Optional fetch buffer: define MEM_CTRL_FETCH_BUF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction-fetch read port
    input  logic              if_r_enable_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_busy_o,
    output logic              if_done_o,
    // load/store port
    input  logic              mem_r_enable_i,
    input  logic              mem_w_enable_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [1:0]        mem_len_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_busy_o,
    output logic              mem_done_o,
    // byte-wide RAM
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    output logic              ram_we_o,
    input  logic [7:0]        ram_rdata_i
);

    import mem_ctrl_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic [CNT_W-1:0]  nbytes;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       asm_data;
    logic [31:0]       rd_word;
    logic [1:0]        rd_lane;

    logic              mem_req;
    logic              mem_ok;
    logic              if_ok;
    logic              accept_mem;
    logic              accept_if;
    logic              if_hit;
    logic              xfer_end;
    logic              fb_hit;
    logic [31:0]       fb_data;

    // A port whose done is showing may not be re-accepted that same cycle;
    // its requester is still holding the old request.
    assign mem_req  = mem_r_enable_i | mem_w_enable_i;
    assign mem_ok   = mem_req & ~mem_done_o;
    assign if_ok    = if_r_enable_i & ~if_done_o;
    assign next_cnt = cnt + 3'd1;

    assign if_busy_o  = rst_n & if_r_enable_i & ~if_done_o;
    assign mem_busy_o = rst_n & mem_req & ~mem_done_o;

    // The byte arriving now belongs to the address issued one cycle earlier.
    assign rd_lane = cnt[1:0] - 2'd1;

    // Merge the arriving RAM byte into the partially assembled word.
    always_comb begin
        rd_word = asm_data;
        rd_word[{rd_lane, 3'b000} +: 8] = ram_rdata_i;
    end

`ifdef MEM_CTRL_FETCH_BUF_EN
    fetch_buf #(
        .ADDR_W      (ADDR_W)
    ) u_fetch_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (if_addr_i),
        .hit         (fb_hit),
        .hit_data    (fb_data),
        .fill_en     ((state == ST_IF_RD) && xfer_end),
        .fill_addr   (req_addr),
        .fill_data   (rd_word),
        .wr_en       (ram_we_o),
        .wr_word     (ram_addr_o[ADDR_W-1:2])
    );
`else
    assign fb_hit  = 1'b0;
    assign fb_data = 32'd0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration and transfer sequencing; MEM beats IF, write beats read.
    always_comb begin
        state_nxt  = state;
        accept_mem = 1'b0;
        accept_if  = 1'b0;
        if_hit     = 1'b0;
        xfer_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_ok) begin
                    accept_mem = 1'b1;
                    state_nxt  = mem_w_enable_i ? ST_MEM_WR : ST_MEM_RD;
                end else if (if_ok) begin
                    accept_if = 1'b1;
                    if (fb_hit) begin
                        if_hit = 1'b1;
                    end else begin
                        state_nxt = ST_IF_RD;
                    end
                end
            end
            // Reads need one extra cycle to capture the last byte.
            ST_IF_RD, ST_MEM_RD: begin
                if (cnt == nbytes) begin
                    xfer_end  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (cnt == nbytes - 3'd1) begin
                    xfer_end  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, RAM drive, byte assembly and done/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            nbytes      <= '0;
            req_addr    <= '0;
            req_wdata   <= '0;
            asm_data    <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ram_we_o    <= 1'b0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            if_done_o   <= 1'b0;
            mem_done_o  <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_mem) begin
                        req_addr   <= mem_addr_i;
                        req_wdata  <= mem_wdata_i;
                        nbytes     <= len_to_bytes(mem_len_i);
                        cnt        <= '0;
                        asm_data   <= '0;
                        ram_addr_o <= mem_addr_i;
                        if (mem_w_enable_i) begin
                            ram_we_o    <= 1'b1;
                            ram_wdata_o <= mem_wdata_i[7:0];
                        end
                    end else if (accept_if) begin
                        if (if_hit) begin
                            if_done_o <= 1'b1;
                            if_data_o <= fb_data;
                        end else begin
                            req_addr   <= if_addr_i;
                            nbytes     <= IF_BYTES;
                            cnt        <= '0;
                            asm_data   <= '0;
                            ram_addr_o <= if_addr_i;
                        end
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    cnt <= next_cnt;
                    if (cnt != '0) begin
                        asm_data <= rd_word;
                    end
                    // Address holds at the last byte during the capture cycle.
                    if (next_cnt < nbytes) begin
                        ram_addr_o <= req_addr + ADDR_W'(next_cnt);
                    end
                    if (xfer_end) begin
                        if (state == ST_IF_RD) begin
                            if_done_o <= 1'b1;
                            if_data_o <= rd_word;
                        end else begin
                            mem_done_o  <= 1'b1;
                            mem_rdata_o <= rd_word;
                        end
                    end
                end
                ST_MEM_WR: begin
                    cnt <= next_cnt;
                    if (xfer_end) begin
                        ram_we_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                    end else begin
                        ram_addr_o  <= req_addr + ADDR_W'(next_cnt);
                        ram_wdata_o <= req_wdata[{next_cnt[1:0], 3'b000} +: 8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Directed self-checking bench for mem_ctrl with a byte RAM
//                model. Fetch-buffer scenarios follow MEM_CTRL_FETCH_BUF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_r_enable_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_busy_o;
    logic        if_done_o;
    logic        mem_r_enable_i;
    logic        mem_w_enable_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_rdata_o;
    logic        mem_busy_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_wdata_o;
    logic        ram_we_o;
    logic [7:0]  ram_rdata_i;

    int vectors;
    int miscompares;

    logic [7:0]  ram [0:1023];

    logic [31:0] addr_log [0:15];
    logic [7:0]  wd_log   [0:15];
    logic [15:0] we_log;
    logic [15:0] ifd_log;
    logic [15:0] md_log;
    logic [15:0] ifb_log;
    logic [15:0] mb_log;
    logic [31:0] if_data_done;
    logic [31:0] mem_rdata_done;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_r_enable_i  (if_r_enable_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_busy_o      (if_busy_o),
        .if_done_o      (if_done_o),
        .mem_r_enable_i (mem_r_enable_i),
        .mem_w_enable_i (mem_w_enable_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_len_i      (mem_len_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_busy_o     (mem_busy_o),
        .mem_done_o     (mem_done_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_we_o       (ram_we_o),
        .ram_rdata_i    (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM model: read data one cycle after address, low 10 address bits.
    always @(posedge clk) begin
        if (ram_we_o) ram[ram_addr_o[9:0]] <= ram_wdata_o;
        ram_rdata_i <= ram[ram_addr_o[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        we_log = '0; ifd_log = '0; md_log = '0; ifb_log = '0; mb_log = '0;
        if_data_done = 32'hxxxxxxxx; mem_rdata_done = 32'hxxxxxxxx;
        for (int i = 0; i < 16; i++) begin
            addr_log[i] = '0;
            wd_log[i]   = '0;
        end
    endtask

    // Record n cycles starting at cycle 0 (current cycle); each port drops
    // its request on the edge after its done pulse.
    task automatic run_log(input int n);
        clear_logs();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            addr_log[c] = ram_addr_o;
            wd_log[c]   = ram_wdata_o;
            we_log[c]   = ram_we_o;
            ifd_log[c]  = if_done_o;
            md_log[c]   = mem_done_o;
            ifb_log[c]  = if_busy_o;
            mb_log[c]   = mem_busy_o;
            if (if_done_o)  if_data_done   = if_data_o;
            if (mem_done_o) mem_rdata_done = mem_rdata_o;
            @(posedge clk);
            #1;
            if (ifd_log[c]) if_r_enable_i = 1'b0;
            if (md_log[c]) begin
                mem_r_enable_i = 1'b0;
                mem_w_enable_i = 1'b0;
            end
        end
    endtask

    task automatic issue_if(input logic [31:0] a);
        if_r_enable_i = 1'b1;
        if_addr_i     = a;
    endtask

    task automatic issue_mem(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] len);
        mem_r_enable_i = ~wr;
        mem_w_enable_i = wr;
        mem_addr_i     = a;
        mem_wdata_i    = d;
        mem_len_i      = len;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        if_r_enable_i  = 1'b0;
        if_addr_i      = '0;
        mem_r_enable_i = 1'b0;
        mem_w_enable_i = 1'b0;
        mem_addr_i     = '0;
        mem_wdata_i    = '0;
        mem_len_i      = '0;
        for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
        ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05;
        ram[10'h000] <= 8'h11; ram[10'h001] <= 8'h22;
        ram[10'h002] <= 8'h33; ram[10'h003] <= 8'h44;
        ram[10'h3FF] <= 8'hAB;

        // Reset state
        #12;
        check("rst_flags", {27'd0, if_busy_o, if_done_o, mem_busy_o, mem_done_o, ram_we_o}, 32'd0);
        check("rst_if_data", if_data_o, 32'd0);
        check("rst_mem_rdata", mem_rdata_o, 32'd0);
        check("rst_ram_addr", ram_addr_o, 32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IF word read at 0x100
        issue_if(32'h100);
        run_log(8);
        check("if_rd_addr1", addr_log[1], 32'h100);
        check("if_rd_addr2", addr_log[2], 32'h101);
        check("if_rd_addr4", addr_log[4], 32'h103);
        check("if_rd_done", {16'd0, ifd_log}, 32'h0040);
        check("if_rd_busy", {16'd0, ifb_log}, 32'h003F);
        check("if_rd_data", if_data_done, 32'h00000513);
        check("if_rd_no_we", {16'd0, we_log}, 32'h0000);

        // Simultaneous IF read 0x0 and MEM word write 0x200
        issue_if(32'h0);
        issue_mem(1'b1, 32'h200, 32'hDEADBEEF, 2'b10);
        run_log(14);
        check("wr_we", {16'd0, we_log}, 32'h001E);
        check("wr_addr1", addr_log[1], 32'h200);
        check("wr_addr4", addr_log[4], 32'h203);
        check("wr_bytes", {wd_log[1], wd_log[2], wd_log[3], wd_log[4]}, 32'hEFBEADDE);
        check("wr_mem_done", {16'd0, md_log}, 32'h0020);
        check("wr_mem_busy", {16'd0, mb_log}, 32'h001F);
        check("wr_if_busy", {16'd0, ifb_log}, 32'h07FF);
        check("wr_if_addr6", addr_log[6], 32'h0);
        check("wr_if_addr9", addr_log[9], 32'h3);
        check("wr_if_done", {16'd0, ifd_log}, 32'h0800);
        check("wr_if_data", if_data_done, 32'h44332211);

        // MEM byte read 0x203
        issue_mem(1'b0, 32'h203, 32'h0, 2'b00);
        run_log(5);
        check("bt_addr1", addr_log[1], 32'h203);
        check("bt_done", {16'd0, md_log}, 32'h0008);
        check("bt_busy", {16'd0, mb_log}, 32'h0007);
        check("bt_data", mem_rdata_done, 32'h000000DE);
        check("bt_if_hold", if_data_o, 32'h44332211);

        // Half read wrapping across the top of the address space
        issue_mem(1'b0, 32'hFFFFFFFF, 32'h0, 2'b01);
        run_log(6);
        check("hw_addr1", addr_log[1], 32'hFFFFFFFF);
        check("hw_addr2", addr_log[2], 32'h00000000);
        check("hw_addr3", addr_log[3], 32'h00000000);
        check("hw_done", {16'd0, md_log}, 32'h0010);
        check("hw_data", mem_rdata_done, 32'h000011AB);
        check("hw_hold", mem_rdata_o, 32'h000011AB);

        // Reset while byte 2 of a word write is on the RAM bus
        issue_mem(1'b1, 32'h300, 32'h01020304, 2'b10);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        check("rw_we_before", {31'd0, ram_we_o}, 32'd1);
        check("rw_addr_before", ram_addr_o, 32'h302);
        rst_n = 1'b0;
        #1;
        check("rw_we_reset", {31'd0, ram_we_o}, 32'd0);
        check("rw_flags_reset", {29'd0, mem_done_o, mem_busy_o, if_done_o}, 32'd0);
        mem_w_enable_i = 1'b0;
        mem_r_enable_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rw_ram_b1", {24'd0, ram[10'h301]}, 32'h03);
        check("rw_ram_b2", {24'd0, ram[10'h302]}, 32'h00);
        issue_mem(1'b0, 32'h301, 32'h0, 2'b00);
        run_log(5);
        check("rw_after_done", {16'd0, md_log}, 32'h0008);
        check("rw_after_data", mem_rdata_done, 32'h00000003);

`ifdef MEM_CTRL_FETCH_BUF_EN
        // Fetch buffer: miss, hit, invalidate by byte store, miss again
        issue_if(32'h100);
        run_log(8);
        check("fb_miss_done", {16'd0, ifd_log}, 32'h0040);
        issue_if(32'h100);
        run_log(4);
        check("fb_hit_done", {16'd0, ifd_log}, 32'h0002);
        check("fb_hit_data", if_data_done, 32'h00000513);
        check("fb_hit_addr1", addr_log[1], addr_log[0]);
        check("fb_hit_addr2", addr_log[2], 32'h103);
        issue_mem(1'b1, 32'h102, 32'h00000077, 2'b00);
        run_log(4);
        check("fb_st_done", {16'd0, md_log}, 32'h0004);
        issue_if(32'h100);
        run_log(8);
        check("fb_refetch_done", {16'd0, ifd_log}, 32'h0040);
        check("fb_refetch_data", if_data_done, 32'h00770513);
`else
        // No buffer: a repeated fetch goes to RAM again
        issue_if(32'h100);
        run_log(8);
        check("nb_first_done", {16'd0, ifd_log}, 32'h0040);
        issue_if(32'h100);
        run_log(8);
        check("nb_second_done", {16'd0, ifd_log}, 32'h0040);
        check("nb_second_addr1", addr_log[1], 32'h100);
        check("nb_second_data", if_data_done, 32'h00000513);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
